// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus Wishbone bridge.
package hyperbus_pkg;

   localparam int         LATE_W   = 4;
   localparam logic [3:0] SEL_FULL = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_RD_REQ,
      S_RD_WAIT,
      S_ACK,
      S_ERR
   } state_e;

   // Saturating up/down step; simultaneous inc and dec cancel out.
   function automatic logic [LATE_W-1:0] late_next(
      input logic [LATE_W-1:0] c,
      input logic              inc,
      input logic              dec
   );
      logic [LATE_W-1:0] r;
      r = c;
      unique case (1'b1)
         inc && !dec && (c != '1): r = c + 1'b1;
         dec && !inc && (c != '0): r = c - 1'b1;
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hyperbus_wb_timeout.sv
// Wait-cycle counter; tc is high on the TIMEOUT-th enabled cycle.
module hyperbus_wb_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone classic slave issuing single-word requests to hyperbus_fifo,
// with timeout errors and draining of read data that arrives too late.
module hyperbus_wb_bridge
   import hyperbus_pkg::*;
#(
   parameter int          ADR_W    = 24,
   parameter logic [31:0] BASE_ADR = 32'h0000_0000,
   parameter int          TIMEOUT  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADR_W-1:0] wb_adr_i,
   input  logic [31:0]      wb_dat_i,
   output logic [31:0]      wb_dat_o,
   input  logic [3:0]       wb_sel_i,
   input  logic             wb_we_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   output logic             wb_ack_o,
   output logic             wb_err_o,
   output logic [31:0]      adr_o,
   output logic [31:0]      tx_dat_o,
   input  logic [31:0]      rx_dat_i,
   output logic             wrq,
   output logic             rrq,
   input  logic             tx_ready,
   input  logic             rx_valid,
   output logic [3:0]       late_cnt_o
);

   state_e            state_q, state_d;
   logic              wrq_q, wrq_d;
   logic              rrq_q, rrq_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       txd_q, txd_d;
   logic [LATE_W-1:0] late_q, late_d;

   logic        req;
   logic        inc;
   logic        dec;
   logic        own_rx;
   logic        tc;
   logic        to_clr;
   logic        to_en;
   logic [31:0] wadr;

   always_comb begin
      wadr = '0;
      wadr[ADR_W-3:0] = wb_adr_i[ADR_W-1:2];
   end

   assign req    = wb_cyc_i && wb_stb_i;
   assign own_rx = rx_valid && (late_q == '0);
   assign dec    = rx_valid && (late_q != '0);

   assign to_clr = (state_q == S_IDLE) || (state_q == S_RD_REQ && rrq_d);
   assign to_en  = (state_q == S_WR_REQ) || (state_q == S_RD_REQ)
                || (state_q == S_RD_WAIT);

   hyperbus_wb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr (to_clr),
      .en  (to_en),
      .tc  (tc)
   );

   always_comb begin
      state_d = state_q;
      wrq_d   = 1'b0;
      rrq_d   = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
      adr_d   = adr_q;
      txd_d   = txd_q;
      inc     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (wb_we_i && wb_sel_i != SEL_FULL) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else if (wb_we_i) begin
                  adr_d   = BASE_ADR + wadr;
                  txd_d   = wb_dat_i;
                  state_d = S_WR_REQ;
               end else begin
                  adr_d   = BASE_ADR + wadr;
                  state_d = S_RD_REQ;
               end
            end
         end
         S_WR_REQ: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (tx_ready) begin
               wrq_d   = 1'b1;
               ack_d   = 1'b1;
               state_d = S_ACK;
            end else if (tc) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end
         end
         S_RD_REQ: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (tx_ready) begin
               rrq_d   = 1'b1;
               state_d = S_RD_WAIT;
            end else if (tc) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end
         end
         S_RD_WAIT: begin
            // An abandoned read still owes us a word unless it lands now.
            if (!wb_cyc_i) begin
               inc     = !own_rx;
               state_d = S_IDLE;
            end else if (own_rx) begin
               dat_d   = rx_dat_i;
               ack_d   = 1'b1;
               state_d = S_ACK;
            end else if (tc) begin
               inc     = 1'b1;
               err_d   = 1'b1;
               state_d = S_ERR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      late_d = late_next(late_q, inc, dec);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wrq_q   <= 1'b0;
         rrq_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         adr_q   <= '0;
         txd_q   <= '0;
         late_q  <= '0;
      end else begin
         state_q <= state_d;
         wrq_q   <= wrq_d;
         rrq_q   <= rrq_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         adr_q   <= adr_d;
         txd_q   <= txd_d;
         late_q  <= late_d;
      end
   end

   assign wb_dat_o   = dat_q;
   assign wb_ack_o   = ack_q;
   assign wb_err_o   = err_q;
   assign adr_o      = adr_q;
   assign tx_dat_o   = txd_q;
   assign wrq        = wrq_q;
   assign rrq        = rrq_q;
   assign late_cnt_o = late_q;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed bench: dut a has BASE_ADR 0, dut b BASE_ADR all-ones (wrap).
module tb_hyperbus_wb_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i  = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [31:0] rx_dat_i = '0;
   logic        tx_ready = 1'b1;
   logic        rx_valid = 1'b0;

   logic [31:0] a_dat, a_adr, a_txd;
   logic        a_ack, a_err, a_wrq, a_rrq;
   logic [3:0]  a_late;
   logic [31:0] b_dat, b_adr, b_txd;
   logic        b_ack, b_err, b_wrq, b_rrq;
   logic [3:0]  b_late;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hyperbus_wb_bridge #(
      .ADR_W    (24),
      .BASE_ADR (32'h0000_0000),
      .TIMEOUT  (16)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_dat_o   (a_dat),
      .wb_sel_i   (wb_sel_i),
      .wb_we_i    (wb_we_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_ack_o   (a_ack),
      .wb_err_o   (a_err),
      .adr_o      (a_adr),
      .tx_dat_o   (a_txd),
      .rx_dat_i   (rx_dat_i),
      .wrq        (a_wrq),
      .rrq        (a_rrq),
      .tx_ready   (tx_ready),
      .rx_valid   (rx_valid),
      .late_cnt_o (a_late)
   );

   hyperbus_wb_bridge #(
      .ADR_W    (24),
      .BASE_ADR (32'hFFFF_FFFF),
      .TIMEOUT  (16)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_dat_o   (b_dat),
      .wb_sel_i   (wb_sel_i),
      .wb_we_i    (wb_we_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_ack_o   (b_ack),
      .wb_err_o   (b_err),
      .adr_o      (b_adr),
      .tx_dat_o   (b_txd),
      .rx_dat_i   (rx_dat_i),
      .wrq        (b_wrq),
      .rrq        (b_rrq),
      .tx_ready   (tx_ready),
      .rx_valid   (rx_valid),
      .late_cnt_o (b_late)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(
      input logic        we,
      input logic [23:0] adr,
      input logic [31:0] dat,
      input logic [3:0]  sel
   );
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
   endtask

   task automatic stop();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic pulse_rx(input logic [31:0] d);
      rx_dat_i = d;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_err(output int n, output int wrqs);
      n    = 0;
      wrqs = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (a_wrq) wrqs++;
         if (a_err) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int wrqs;

      tick();
      tick();
      chk("rst_ack",  32'(a_ack),  32'd0);
      chk("rst_err",  32'(a_err),  32'd0);
      chk("rst_adr",  a_adr,       32'd0);
      chk("rst_dat",  a_dat,       32'd0);
      chk("rst_late", 32'(a_late), 32'd0);
      rst = 1'b0;
      tick();

      // posted write, tx_ready high
      start(1'b1, 24'h000010, 32'hDEADBEEF, 4'hF);
      tick();
      chk("wr_ack_early", 32'(a_ack), 32'd0);
      chk("wr_wrq_early", 32'(a_wrq), 32'd0);
      tick();
      chk("wr_ack",  32'(a_ack), 32'd1);
      chk("wr_wrq",  32'(a_wrq), 32'd1);
      chk("wr_adr",  a_adr,      32'h4);
      chk("wr_txd",  a_txd,      32'hDEADBEEF);
      chk("wr_adr_b", b_adr,     32'h3);
      stop();
      tick();
      chk("wr_wrq_once", 32'(a_wrq), 32'd0);
      chk("wr_ack_once", 32'(a_ack), 32'd0);

      // read with data 5 cycles after rrq
      start(1'b0, 24'h000020, 32'h0, 4'h1);
      tick();
      tick();
      chk("rd_rrq", 32'(a_rrq), 32'd1);
      chk("rd_adr", a_adr,      32'h8);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_rrq || a_ack) n++;
      end
      chk("rd_quiet", 32'(n), 32'd0);
      pulse_rx(32'h12345678);
      chk("rd_ack", 32'(a_ack), 32'd1);
      chk("rd_dat", a_dat,      32'h12345678);
      stop();
      tick();
      chk("rd_ack_once", 32'(a_ack), 32'd0);
      chk("rd_dat_hold", a_dat,      32'h12345678);

      // partial write is rejected
      start(1'b1, 24'h000040, 32'h11112222, 4'h3);
      tick();
      chk("pw_err", 32'(a_err), 32'd1);
      chk("pw_ack", 32'(a_ack), 32'd0);
      chk("pw_wrq", 32'(a_wrq), 32'd0);
      chk("pw_adr_kept", a_adr, 32'h8);
      stop();
      tick();
      chk("pw_err_once", 32'(a_err), 32'd0);

      // write timeout with tx_ready low
      tx_ready = 1'b0;
      start(1'b1, 24'h000010, 32'hCAFEF00D, 4'hF);
      tick();
      wait_err(n, wrqs);
      chk("wto_cycles", 32'(n),    32'd16);
      chk("wto_no_wrq", 32'(wrqs), 32'd0);
      chk("wto_no_ack", 32'(a_ack), 32'd0);
      stop();
      tx_ready = 1'b1;
      tick();

      // read timeout leaves one late word outstanding
      start(1'b0, 24'h000020, 32'h0, 4'hF);
      tick();
      tick();
      wait_err(n, wrqs);
      chk("rto_cycles", 32'(n),      32'd16);
      chk("rto_late",   32'(a_late), 32'd1);
      stop();
      tick();
      start(1'b0, 24'h000020, 32'h0, 4'hF);
      tick();
      tick();
      chk("late_rrq", 32'(a_rrq), 32'd1);
      pulse_rx(32'hAAAA0000);
      chk("late_drop_ack", 32'(a_ack),  32'd0);
      chk("late_drop_cnt", 32'(a_late), 32'd0);
      pulse_rx(32'hBBBB0001);
      chk("late_ack", 32'(a_ack),  32'd1);
      chk("late_dat", a_dat,       32'hBBBB0001);
      chk("late_cnt", 32'(a_late), 32'd0);
      stop();
      tick();

      // master abort in RD_WAIT, then drain outside RD_WAIT
      start(1'b0, 24'h000020, 32'h0, 4'hF);
      tick();
      tick();
      stop();
      tick();
      chk("ab_late", 32'(a_late), 32'd1);
      chk("ab_term", 32'(a_ack | a_err), 32'd0);
      pulse_rx(32'h5555AAAA);
      chk("ab_drain", 32'(a_late), 32'd0);
      chk("ab_hold",  a_dat,       32'hBBBB0001);

      // address wrap with all-ones base
      start(1'b1, 24'h000004, 32'h01020304, 4'hF);
      tick();
      tick();
      chk("wrap_b", b_adr, 32'h0);
      chk("wrap_a", a_adr, 32'h1);
      stop();
      tick();

      // reset in RD_WAIT, then a stray rx_valid
      start(1'b0, 24'h000020, 32'h0, 4'hF);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rr_adr", a_adr, 32'd0);
      chk("rr_dat", a_dat, 32'd0);
      chk("rr_txd", a_txd, 32'd0);
      tick();
      rst = 1'b0;
      stop();
      pulse_rx(32'h77778888);
      chk("rr_term", 32'(a_ack | a_err), 32'd0);
      chk("rr_late", 32'(a_late),        32'd0);
      chk("rr_rrq",  32'(a_rrq),         32'd0);
      tick();
      chk("rr_idle", 32'(a_ack | a_err | a_rrq | a_wrq), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
